// File: rtl/hazard_scheduler_if.sv
// Decode-stage to hazard-scheduler bundle: instruction fields and zero flag in,
// pipeline controls and performance counters out.
interface hazard_scheduler_if #(
    parameter int OPW  = 5,
    parameter int RW   = 2,
    parameter int CNTW = 16
);
    logic            instr_valid;
    logic [OPW-1:0]  opcode;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic            rs1_used;
    logic            rs2_used;
    logic [RW-1:0]   rd;
    logic            rd_we;
    logic            cnt_upd;
    logic            zero_flag;
    logic            stall;
    logic            bubble;
    logic            flush_ifid;
    logic            sel_pc;
    logic            halted;
    logic [CNTW-1:0] stall_cycles;
    logic [CNTW-1:0] flush_count;

    modport master (
        output instr_valid, opcode, rs1, rs2, rs1_used, rs2_used, rd, rd_we, cnt_upd, zero_flag,
        input  stall, bubble, flush_ifid, sel_pc, halted, stall_cycles, flush_count
    );

    modport slave (
        input  instr_valid, opcode, rs1, rs2, rs1_used, rs2_used, rd, rd_we, cnt_upd, zero_flag,
        output stall, bubble, flush_ifid, sel_pc, halted, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_scheduler.sv
// Pipeline sequencing controller: RAW/loop-counter hazard stalls, loop-jump resolution, HALT.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_scheduler #(
    parameter int             OPW     = 5,
    parameter int             RW      = 2,
    parameter logic [OPW-1:0] OP_JMP  = 5'h10,
    parameter logic [OPW-1:0] OP_HALT = 5'h1F,
    parameter int             CNTW    = 16
) (
    input logic               clk,
    input logic               rst,
    hazard_scheduler_if.slave bus
);
    typedef enum logic [1:0] {ST_RUN, ST_BR, ST_HALTED} state_t;

    state_t          state;
    logic            ex_wv, ex_cu, mem_wv, mem_cu;
    logic [RW-1:0]   ex_rd, mem_rd;

    logic            rs1_hit, rs2_hit, cnt_hit, hazard, issue;
    logic            stall_c, bubble_c, flush_c, sel_c, halted_c;

    always_comb begin
        rs1_hit = bus.rs1_used & ((ex_wv & (ex_rd == bus.rs1)) | (mem_wv & (mem_rd == bus.rs1)));
        rs2_hit = bus.rs2_used & ((ex_wv & (ex_rd == bus.rs2)) | (mem_wv & (mem_rd == bus.rs2)));
        cnt_hit = (bus.opcode == OP_JMP) & (ex_cu | mem_cu);
        hazard  = bus.instr_valid & (rs1_hit | rs2_hit | cnt_hit);
    end

    always_comb begin
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        sel_c    = 1'b0;
        halted_c = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (hazard || (bus.instr_valid && bus.opcode == OP_HALT)) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                end else if (bus.instr_valid && bus.opcode == OP_JMP) begin
                    stall_c = 1'b1;
                end
            end
            ST_BR: begin
                bubble_c = 1'b1;
                flush_c  = 1'b1;
                sel_c    = ~bus.zero_flag;
            end
            ST_HALTED: begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
                halted_c = 1'b1;
            end
            default: ;
        endcase
        issue = bus.instr_valid & (state == ST_RUN) & ~hazard & ~bubble_c;
    end

    // Reset overrides every control, including a sel_pc from a pending branch.
    assign bus.stall      = stall_c  & ~rst;
    assign bus.bubble     = bubble_c & ~rst;
    assign bus.flush_ifid = flush_c  & ~rst;
    assign bus.sel_pc     = sel_c    & ~rst;
    assign bus.halted     = halted_c & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_RUN;
            ex_wv  <= 1'b0;
            ex_rd  <= '0;
            ex_cu  <= 1'b0;
            mem_wv <= 1'b0;
            mem_rd <= '0;
            mem_cu <= 1'b0;
        end else begin
            mem_wv <= ex_wv;
            mem_rd <= ex_rd;
            mem_cu <= ex_cu;
            ex_wv  <= issue & bus.rd_we;
            ex_rd  <= issue ? bus.rd : '0;
            ex_cu  <= issue & bus.cnt_upd;
            unique case (state)
                ST_RUN: begin
                    if (!hazard && bus.instr_valid && bus.opcode == OP_HALT)
                        state <= ST_HALTED;
                    else if (issue && bus.opcode == OP_JMP)
                        state <= ST_BR;
                end
                ST_BR:     state <= ST_RUN;
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNTW-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hazard && state == ST_RUN && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_c && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign bus.stall_cycles = rst ? '0 : stall_cnt;
    assign bus.flush_count  = rst ? '0 : flush_cnt;
`else
    assign bus.stall_cycles = {CNTW{1'b0}};
    assign bus.flush_count  = {CNTW{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_scheduler.sv
// Randomized + directed bench for hazard_scheduler against an in-flight-write queue model.
module tb_hazard_scheduler;
    localparam logic [4:0] OP_JMP  = 5'h10;
    localparam logic [4:0] OP_HALT = 5'h1F;
    localparam int unsigned CMAX   = 65535;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scheduler_if #(.OPW(5), .RW(2), .CNTW(16)) bus ();

    hazard_scheduler #(
        .OPW(5), .RW(2), .OP_JMP(OP_JMP), .OP_HALT(OP_HALT), .CNTW(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // Model: writes issued in the last two cycles are still in flight.
    typedef struct {bit wv; bit [1:0] rd; bit cu;} wr_t;
    wr_t         inflight[$];
    bit          m_halt, m_br;
    int unsigned m_sc, m_fc;
    bit          e_stall, e_bubble, e_flush, e_sel, e_halted, m_haz, m_issue, m_go_halt;
    bit          s_stall, s_bubble, s_flush, s_sel, s_halted;

    task automatic model_eval();
        {e_stall, e_bubble, e_flush, e_sel, e_halted} = '0;
        m_haz = 0; m_issue = 0; m_go_halt = 0;
        if (!rst) begin
            if (m_halt) begin
                e_stall = 1; e_bubble = 1; e_halted = 1;
            end else if (m_br) begin
                e_bubble = 1; e_flush = 1; e_sel = !bus.zero_flag;
            end else if (bus.instr_valid) begin
                foreach (inflight[i]) begin
                    if (inflight[i].wv && ((bus.rs1_used && inflight[i].rd == bus.rs1) ||
                                           (bus.rs2_used && inflight[i].rd == bus.rs2)))
                        m_haz = 1;
                    if (inflight[i].cu && bus.opcode == OP_JMP)
                        m_haz = 1;
                end
                if (m_haz) begin
                    e_stall = 1; e_bubble = 1;
                end else if (bus.opcode == OP_HALT) begin
                    e_stall = 1; e_bubble = 1; m_go_halt = 1;
                end else begin
                    m_issue = 1;
                    e_stall = (bus.opcode == OP_JMP);
                end
            end
        end
    endtask

    task automatic model_commit();
        wr_t w;
        if (rst) begin
            inflight.delete();
            m_halt = 0; m_br = 0; m_sc = 0; m_fc = 0;
        end else begin
            w.wv = m_issue && bus.rd_we;
            w.rd = m_issue ? bus.rd : 2'd0;
            w.cu = m_issue && bus.cnt_upd;
            inflight.push_front(w);
            if (inflight.size() > 2) void'(inflight.pop_back());
            m_br   = m_issue && bus.opcode == OP_JMP;
            m_halt = m_halt || m_go_halt;
            if (m_haz && m_sc < CMAX) m_sc++;
            if (e_flush && m_fc < CMAX) m_fc++;
        end
    endtask

    task automatic cycle_check();
        @(negedge clk);
        model_eval();
        s_stall = bus.stall; s_bubble = bus.bubble; s_flush = bus.flush_ifid;
        s_sel = bus.sel_pc; s_halted = bus.halted;
        check_eq("stall",  32'(s_stall),  32'(e_stall));
        check_eq("bubble", 32'(s_bubble), 32'(e_bubble));
        check_eq("flush",  32'(s_flush),  32'(e_flush));
        check_eq("sel_pc", 32'(s_sel),    32'(e_sel));
        check_eq("halted", 32'(s_halted), 32'(e_halted));
`ifdef HAZARD_PERF_CNT_EN
        check_eq("stall_cycles", 32'(bus.stall_cycles), rst ? 32'd0 : m_sc);
        check_eq("flush_count",  32'(bus.flush_count),  rst ? 32'd0 : m_fc);
`else
        check_eq("stall_cycles", 32'(bus.stall_cycles), 32'd0);
        check_eq("flush_count",  32'(bus.flush_count),  32'd0);
`endif
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_instr(input bit v, input logic [4:0] op,
                             input logic [1:0] r1, input bit u1, input logic [1:0] r2, input bit u2,
                             input logic [1:0] d, input bit we, input bit cu);
        bus.instr_valid = v; bus.opcode = op;
        bus.rs1 = r1; bus.rs1_used = u1; bus.rs2 = r2; bus.rs2_used = u2;
        bus.rd = d; bus.rd_we = we; bus.cnt_upd = cu;
    endtask

    task automatic rand_instr();
        int unsigned k;
        logic [4:0]  op;
        k  = $urandom_range(0, 99);
        op = 5'($urandom_range(0, 15));
        if (k < 10)      op = OP_JMP;
        else if (k < 12) op = OP_HALT;
        set_instr(($urandom_range(0, 7) != 0), op,
                  2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                  2'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
        bus.zero_flag = 1'($urandom);
    endtask

    // Runs reader cycles until stall drops; returns number of stalled cycles.
    task automatic count_stalls(output int unsigned n);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            cycle_check();
            if (!s_stall) break;
            n++;
        end
    endtask

    int unsigned ns;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        set_instr(0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        bus.zero_flag = 0;
        rst = 1;
        cycle_check();
        cycle_check();
        rst = 0;

        // Reader right behind writer: two stalls.
        set_instr(1, 5'd1, 0, 0, 0, 0, 2'd1, 1, 0);
        cycle_check();
        set_instr(1, 5'd2, 2'd1, 1, 0, 0, 2'd0, 0, 0);
        count_stalls(ns);
        check_eq("raw_ex_stalls", ns, 2);

        // One unrelated instruction in between: one stall.
        set_instr(1, 5'd1, 0, 0, 0, 0, 2'd2, 1, 0);
        cycle_check();
        set_instr(1, 5'd3, 0, 0, 0, 0, 0, 0, 0);
        cycle_check();
        set_instr(1, 5'd2, 0, 0, 2'd2, 1, 0, 0, 0);
        count_stalls(ns);
        check_eq("raw_mem_stalls", ns, 1);

        // Same distance but source not read: no stall.
        set_instr(1, 5'd1, 0, 0, 0, 0, 2'd2, 1, 0);
        cycle_check();
        set_instr(1, 5'd3, 0, 0, 0, 0, 0, 0, 0);
        cycle_check();
        set_instr(1, 5'd2, 0, 0, 2'd2, 0, 0, 0, 0);
        count_stalls(ns);
        check_eq("unused_src_stalls", ns, 0);

        // Counter update then jump: two hazard stalls, jump issues, loop taken.
        set_instr(1, 5'd4, 0, 0, 0, 0, 0, 0, 1);
        cycle_check();
        set_instr(1, OP_JMP, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) cycle_check();
        cycle_check();
        bus.zero_flag = 0;
        cycle_check();
        check_eq("br_taken_sel", 32'(s_sel), 1);
        check_eq("br_taken_flush", 32'(s_flush), 1);

        // Jump with zero flag set: fall through, then back to idle controls.
        set_instr(1, OP_JMP, 0, 0, 0, 0, 0, 0, 0);
        cycle_check();
        bus.zero_flag = 1;
        cycle_check();
        check_eq("br_fall_sel", 32'(s_sel), 0);
        check_eq("br_fall_flush", 32'(s_flush), 1);
        set_instr(1, 5'd5, 0, 0, 0, 0, 0, 0, 0);
        cycle_check();
        check_eq("post_br_stall", 32'(s_stall), 0);

        // HALT holds regardless of inputs until reset.
        set_instr(1, OP_HALT, 0, 0, 0, 0, 0, 0, 0);
        cycle_check();
        for (int i = 0; i < 12; i++) begin
            rand_instr();
            cycle_check();
        end
        check_eq("halt_held", 32'(s_halted), 1);
        rst = 1;
        cycle_check();
        rst = 0;
        set_instr(1, 5'd6, 0, 0, 0, 0, 2'd3, 1, 0);
        cycle_check();
        check_eq("resume_stall", 32'(s_stall), 0);

        // Reset during the branch cycle discards the branch and the scoreboard.
        set_instr(1, 5'd1, 0, 0, 0, 0, 2'd3, 1, 0);
        cycle_check();
        set_instr(1, OP_JMP, 0, 0, 0, 0, 0, 0, 0);
        cycle_check();
        bus.zero_flag = 0;
        rst = 1;
        cycle_check();
        check_eq("rst_br_sel", 32'(s_sel), 0);
        rst = 0;
        set_instr(1, 5'd2, 2'd3, 1, 0, 0, 0, 0, 0);
        cycle_check();
        check_eq("rst_sb_clear", 32'(s_stall), 0);

        for (int i = 0; i < 3000; i++) begin
            rand_instr();
            if (m_halt) rst = ($urandom_range(0, 7) == 0);
            else        rst = ($urandom_range(0, 99) == 0);
            cycle_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Pipeline sequencing controller for the 4-stage vector encryption CPU (fetch, decode, execute, memory/writeback).
- Tracks in-flight vector-register and loop-counter writes, and stalls decode on read-after-write hazards.
- Resolves the loop jump from the execute-stage compare zero flag, and halts the core on HALT.
- Drives the PC-hold, IF/ID-flush, ID/EXE-bubble and PC-mux select controls.

Parameters:
- OPW, 5, opcode width (instruction bits [12:8]).
- RW, 2, vector register address width.
- OP_JMP, 5'h10, opcode of the conditional loop jump.
- OP_HALT, 5'h1F, opcode that stops the core.
- CNTW, 16, performance counter width (optional feature only).

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  IF/ID holds a real (non-NOP) instruction
- opcode  in  OPW  decode opcode
- rs1, rs2  in  RW each  decode source registers (inst[5:4], inst[3:2])
- rs1_used, rs2_used  in  1 each  source actually read by this opcode
- rd  in  RW  decode destination (inst[7:6])
- rd_we  in  1  decode instruction writes a vector register (regWriteD)
- cnt_upd  in  1  decode instruction updates loop counter (updateCount)
- zero_flag  in  1  execute-stage counter compare result
- stall  out  1  hold PC and IF/ID
- bubble  out  1  load NOP/zero controls into ID/EXE
- flush_ifid  out  1  clear IF/ID to NOP on next edge
- sel_pc  out  1  PC mux selects jump target
- halted  out  1  core halted
- stall_cycles, flush_count  out  CNTW each  performance counters

Behaviour:
- Clock/reset: one clock, clk. rst is synchronous, active-high.
- Reset actions: state=RUN, scoreboard cleared, counters=0.
- Outputs are combinational from state, scoreboard and inputs. All outputs are forced 0 while rst=1.
- Scoreboard: two slots, EX and MEM, each {wv, rd, cu}. Every non-reset edge: MEM<=EX; EX<={rd_we,rd,cu} when issue=1, else zeros.
  - issue = instr_valid & state==RUN & !hazard & !bubble.
- Write timing: register files write at the rising edge of an instruction's MEM cycle. Hence EX and MEM slots are both hazards, giving at most 2 stall cycles.
- hazard = instr_valid & ((rs1_used & (EX.wv&EX.rd==rs1 | MEM.wv&MEM.rd==rs1)) | (rs2_used & same for rs2) | (opcode==OP_JMP & (EX.cu|MEM.cu))).
- State RUN, priority hazard > HALT > JMP > normal:
  - hazard: stall=1, bubble=1, state unchanged.
  - opcode==OP_HALT: stall=1, bubble=1, next HALTED.
  - opcode==OP_JMP: issue; stall=1 (PC and IF/ID hold the jump); next BR.
  - otherwise: issue; all controls 0.
  - instr_valid=0: no issue, all controls 0.
- State BR (jump is in execute, zero_flag valid this cycle):
  - bubble=1, so the held jump is not re-issued; flush_ifid=1; stall=0.
  - zero_flag=0 (loop continues): sel_pc=1.
  - zero_flag=1: sel_pc=0 (fall through).
  - next RUN.
- State HALTED: stall=1, bubble=1, halted=1. Scoreboard still drains. Only rst exits.
- Inputs are don't-care during BR and HALTED.
- Reset mid-operation (e.g. in BR): next state RUN, pending branch discarded, sel_pc=0.
- A jump immediately followed by a jump: the second jump is fetched only after BR, so no overlap.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on each non-reset cycle with hazard=1.
  - flush_count increments each cycle flush_ifid=1.
  - Both saturate at 2^CNTW-1 and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Writes R1 (rd_we=1, rd=1), next instr rs1=1 rs1_used=1 -> stall=bubble=1 for exactly 2 cycles, issue on 3rd; stall_cycles=2 with macro.
- Writes R2, then unrelated instr, then reader of R2 -> exactly 1 stall cycle; with rs2_used=0 on the reader -> 0 stalls.
- cnt_upd instr, then OP_JMP -> 2 stall cycles, JMP issues, BR cycle with zero_flag=0 -> sel_pc=1, flush_ifid=1, bubble=1; flush_count=1.
- OP_JMP with zero_flag=1 in BR -> sel_pc=0, flush_ifid=1; next cycle state RUN, controls 0.
- OP_HALT -> halted=1, stall=bubble=1 held 10+ cycles regardless of inputs; rst=1 one cycle -> all outputs 0, normal issue resumes.
- rst asserted during BR -> sel_pc=0 that cycle, scoreboard empty afterwards (reader of prior rd does not stall).
